stage3_sequencer: RTL and testbench

STAGE3_SEQUENCER -- requirements
Module: stage3_sequencer

---
 rtl/stage3_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_stage3_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stage3_sequencer.sv
// rtl/stage3_sequencer.sv - Multi-cycle operation sequencer driving ALU/shifter result writes
//
// Purpose: accepts one operation request at a time (ALU, SHIFT, CMP or REPEAT),
// steps it through EXEC / LOOP / DONE, and drives the datapath controls for
// each cycle. Outputs are registered decodes of the next state and latched
// fields. ResWrite is additionally masked by the live Flush input.
//
// Ports:
//   CLK         in   clock, rising-edge
//   Reset_n     in   synchronous active-low reset
//   Req         in   request a new operation (honoured only while Ready)
//   Kind[1:0]   in   00 ALU, 01 SHIFT, 10 CMP, 11 REPEAT
//   OpIn[3:0]   in   ALU opcode for the operation
//   Count[3:0]  in   REPEAT iteration count (0 behaves as 1)
//   Flush       in   abort the operation in progress
//   isZero      in   ALU zero flag, captured by CMP
//   Ready       out  idle and accepting requests
//   ALUop[3:0]  out  ALU opcode drive
//   ResSource   out  Res source select: 0 ALU, 1 shifter
//   ResWrite    out  Res register write enable
//   FeedbackSel out  route Res back as ALU A operand
//   Done        out  one-cycle completion pulse
//   ZeroFlag    out  registered compare result
//   Busy        out  operation in progress
module stage3_sequencer (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Req,
  input  logic [1:0] Kind,
  input  logic [3:0] OpIn,
  input  logic [3:0] Count,
  input  logic       Flush,
  input  logic       isZero,
  output logic       Ready,
  output logic [3:0] ALUop,
  output logic       ResSource,
  output logic       ResWrite,
  output logic       FeedbackSel,
  output logic       Done,
  output logic       ZeroFlag,
  output logic       Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_LOOP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] K_SHIFT  = 2'd1;
  localparam logic [1:0] K_CMP    = 2'd2;
  localparam logic [1:0] K_REPEAT = 2'd3;

  state_t     state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic [3:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rem_q, rem_d;
  logic       zero_q, zero_d;

  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic [3:0] aluop_q, aluop_d;
  logic       res_src_q, res_src_d;
  logic       res_wr_q, res_wr_d;
  logic       fb_q, fb_d;
  logic       done_q, done_d;

  logic [3:0] eff_cnt;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    // A zero count still performs one iteration.
    eff_cnt = (cnt_q == 4'd0) ? 4'd1 : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (Req && !Flush) begin
          state_d = S_EXEC;
          kind_d  = Kind;
          op_d    = OpIn;
          cnt_d   = Count;
        end
      end
      S_EXEC: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          if (kind_q == K_CMP) begin
            zero_d = isZero;
          end
          // EXEC already performs the first write, so LOOP handles the rest.
          if (kind_q == K_REPEAT && eff_cnt != 4'd1) begin
            state_d = S_LOOP;
            rem_d   = eff_cnt - 4'd1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOOP: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else if (rem_q == 4'd1) begin
          state_d = S_DONE;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output decode of the state being entered, so outputs come straight from flops.
    ready_d   = 1'b0;
    busy_d    = 1'b0;
    aluop_d   = 4'd0;
    res_src_d = 1'b0;
    res_wr_d  = 1'b0;
    fb_d      = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
      end
      S_EXEC: begin
        busy_d    = 1'b1;
        aluop_d   = op_d;
        res_src_d = (kind_d == K_SHIFT);
        res_wr_d  = (kind_d != K_CMP);
      end
      S_LOOP: begin
        busy_d   = 1'b1;
        aluop_d  = op_d;
        fb_d     = 1'b1;
        res_wr_d = 1'b1;
      end
      S_DONE: begin
        busy_d  = 1'b1;
        aluop_d = op_d;
        done_d  = 1'b1;
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      kind_q    <= 2'd0;
      op_q      <= 4'd0;
      cnt_q     <= 4'd0;
      rem_q     <= 4'd0;
      zero_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      aluop_q   <= 4'd0;
      res_src_q <= 1'b0;
      res_wr_q  <= 1'b0;
      fb_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      zero_q    <= zero_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      aluop_q   <= aluop_d;
      res_src_q <= res_src_d;
      res_wr_q  <= res_wr_d;
      fb_q      <= fb_d;
      done_q    <= done_d;
    end
  end

  assign Ready       = ready_q;
  assign Busy        = busy_q;
  assign ALUop       = aluop_q;
  assign ResSource   = res_src_q;
  // Flush must suppress the write in the very cycle it is raised.
  assign ResWrite    = res_wr_q & ~Flush;
  assign FeedbackSel = fb_q;
  assign Done        = done_q;
  assign ZeroFlag    = zero_q;

endmodule

// File: tb/tb_stage3_sequencer.sv
// tb/tb_stage3_sequencer.sv - Scoreboard bench for stage3_sequencer
module tb_stage3_sequencer;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req = 1'b0;
  logic [1:0] Kind = 2'd0;
  logic [3:0] OpIn = 4'd0;
  logic [3:0] Count = 4'd0;
  logic       Flush = 1'b0;
  logic       isZero = 1'b0;
  logic       Ready;
  logic [3:0] ALUop;
  logic       ResSource;
  logic       ResWrite;
  logic       FeedbackSel;
  logic       Done;
  logic       ZeroFlag;
  logic       Busy;

  always #5 CLK = ~CLK;

  stage3_sequencer dut (
    .CLK(CLK), .Reset_n(Reset_n), .Req(Req), .Kind(Kind), .OpIn(OpIn),
    .Count(Count), .Flush(Flush), .isZero(isZero), .Ready(Ready),
    .ALUop(ALUop), .ResSource(ResSource), .ResWrite(ResWrite),
    .FeedbackSel(FeedbackSel), .Done(Done), .ZeroFlag(ZeroFlag), .Busy(Busy)
  );

  // One expected cycle of an operation's schedule.
  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [3:0] aluop;
    logic       ressrc;
    logic       reswr;
    logic       fb;
    logic       done;
    logic       cmp;
  } rec_t;

  rec_t        sched[$];
  logic [10:0] expq[$];
  int          checks = 0;
  int          failures = 0;
  logic        zf_m = 1'b0;
  bit          known = 1'b0;

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  // Operation as a list of cycles: one EXEC, N-1 feedback cycles for REPEAT, one DONE.
  function automatic void build(input logic [1:0] k, input logic [3:0] op, input logic [3:0] cn);
    rec_t r;
    int   n;
    n = (cn == 4'd0) ? 1 : int'(cn);
    r = '0;
    r.busy = 1'b1; r.aluop = op; r.ressrc = (k == 2'd1);
    r.reswr = (k != 2'd2); r.cmp = (k == 2'd2);
    sched.push_back(r);
    if (k == 2'd3) begin
      for (int i = 1; i < n; i++) begin
        r = '0;
        r.busy = 1'b1; r.aluop = op; r.fb = 1'b1; r.reswr = 1'b1;
        sched.push_back(r);
      end
    end
    r = '0;
    r.busy = 1'b1; r.aluop = op; r.done = 1'b1;
    sched.push_back(r);
  endfunction

  task automatic step(input logic rn, input logic rq, input logic [1:0] k, input logic [3:0] op,
                      input logic [3:0] cn, input logic fl, input logic iz);
    rec_t cur;
    @(posedge CLK);
    #2;
    Reset_n = rn; Req = rq; Kind = k; OpIn = op; Count = cn; Flush = fl; isZero = iz;
    if (known) begin
      cur = (sched.size() > 0) ? sched[0] : idle_rec();
      if (fl) cur.reswr = 1'b0;
      expq.push_back({cur.ready, cur.busy, cur.aluop, cur.ressrc, cur.reswr,
                      cur.fb, cur.done, zf_m});
    end
    if (!rn) begin
      sched.delete();
      zf_m  = 1'b0;
      known = 1'b1;
    end else if (sched.size() > 0) begin
      if (fl) begin
        sched.delete();
      end else begin
        cur = sched.pop_front();
        if (cur.cmp) zf_m = iz;
      end
    end else if (rq && !fl) begin
      build(k, op, cn);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic go(input logic [1:0] k, input logic [3:0] op, input logic [3:0] cn);
    step(1'b1, 1'b1, k, op, cn, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    logic [10:0] exp_v;
    logic [10:0] act_v;
    forever begin
      @(negedge CLK);
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        act_v = {Ready, Busy, ALUop, ResSource, ResWrite, FeedbackSel, Done, ZeroFlag};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL outputs t=%0t {Ready,Busy,ALUop,ResSource,ResWrite,FeedbackSel,Done,ZeroFlag} actual=%b required=%b",
                   $time, act_v, exp_v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 4'd7, 4'd9, 1'b0, 1'b0);
    idle(2);

    go(2'd0, 4'd3, 4'd0); idle(3);                     // ALU
    go(2'd1, 4'd5, 4'd0); idle(3);                     // SHIFT
    go(2'd2, 4'd9, 4'd0);                              // CMP, isZero=1 in EXEC
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1); idle(3);
    go(2'd2, 4'd2, 4'd0);                              // CMP, isZero=0 clears
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0); idle(3);
    go(2'd3, 4'd6, 4'd4); idle(7);                     // REPEAT 4
    go(2'd3, 4'd1, 4'd0); idle(3);                     // REPEAT 0 -> one pass
    go(2'd3, 4'd8, 4'd15); idle(18);                   // REPEAT max
    go(2'd3, 4'd4, 4'd5); idle(2);                     // Flush in second LOOP cycle
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0); idle(3);
    step(1'b1, 1'b1, 2'd0, 4'd1, 4'd0, 1'b1, 1'b0); idle(2); // Req+Flush in IDLE
    go(2'd2, 4'd0, 4'd0);                              // CMP with flush in EXEC keeps ZeroFlag
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b1); idle(2);
    go(2'd2, 4'd0, 4'd0);                              // set ZeroFlag before reset test
    step(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1); idle(2);
    go(2'd3, 4'd7, 4'd6); idle(2);                     // reset during LOOP
    step(1'b0, 1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0); idle(3);
    for (int i = 0; i < 8; i++) go(2'd3, 4'd2, 4'd3);  // Req held while busy
    idle(3);
    go(2'd1, 4'd6, 4'd0);                              // Flush in DONE
    idle(1);
    step(1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 1'b1, 1'b0); idle(3);

    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           logic'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end
    idle(20);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
